// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one registered Alu, with per-requester response buffers
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority to r0.
module alu_arbiter #(
  parameter int OPW = 5,
  parameter int DW  = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           r0_valid,
  output logic           r0_ready,
  input  logic [OPW-1:0] r0_op,
  input  logic [DW-1:0]  r0_a,
  input  logic [DW-1:0]  r0_b,
  output logic           r0_rsp_valid,
  input  logic           r0_rsp_ready,
  output logic [DW-1:0]  r0_rsp_data,
  input  logic           r1_valid,
  output logic           r1_ready,
  input  logic [OPW-1:0] r1_op,
  input  logic [DW-1:0]  r1_a,
  input  logic [DW-1:0]  r1_b,
  output logic           r1_rsp_valid,
  input  logic           r1_rsp_ready,
  output logic [DW-1:0]  r1_rsp_data,
  output logic [OPW-1:0] alu_op,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  input  logic [DW-1:0]  alu_out
);

  // Unmapped op code: Alu holds its output while nobody is granted.
  localparam logic [OPW-1:0] OP_IDLE = OPW'(31);

  logic          r_tag_valid;
  logic          r_tag_id;
  logic          r_rsp_valid0;
  logic          r_rsp_valid1;
  logic [DW-1:0] r_rsp_data0;
  logic [DW-1:0] r_rsp_data1;

  logic w_inflight0;
  logic w_inflight1;
  logic w_elig0;
  logic w_elig1;
  logic w_grant0;
  logic w_grant1;
  logic w_accept;

  assign w_inflight0 = r_tag_valid & ~r_tag_id;
  assign w_inflight1 = r_tag_valid & r_tag_id;

  // A full buffer only blocks issue if it is not being drained this cycle.
  assign w_elig0 = r0_valid & ~w_inflight0 & (~r_rsp_valid0 | r0_rsp_ready);
  assign w_elig1 = r1_valid & ~w_inflight1 & (~r_rsp_valid1 | r1_rsp_ready);

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic r_last_id;

  assign w_grant0 = w_elig0 & (~w_elig1 | r_last_id);

  // Reset to "r1 last" so r0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_id <= 1'b1;
    end else if (w_accept) begin
      r_last_id <= w_grant1;
    end
  end
`else
  assign w_grant0 = w_elig0;
`endif

  assign w_grant1 = w_elig1 & ~w_grant0;
  assign w_accept = w_grant0 | w_grant1;

  assign r0_ready = w_grant0;
  assign r1_ready = w_grant1;

  always_comb begin
    alu_op = OP_IDLE;
    alu_a  = '0;
    alu_b  = '0;
    if (w_grant0) begin
      alu_op = r0_op;
      alu_a  = r0_a;
      alu_b  = r0_b;
    end else if (w_grant1) begin
      alu_op = r1_op;
      alu_a  = r1_a;
      alu_b  = r1_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_valid <= 1'b0;
      r_tag_id    <= 1'b0;
    end else begin
      r_tag_valid <= w_accept;
      if (w_accept) begin
        r_tag_id <= w_grant1;
      end
    end
  end

  // Capture and drain never hit the same buffer in one cycle: the issue that
  // produced the capture already required that buffer to be empty or draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid0 <= 1'b0;
      r_rsp_data0  <= '0;
    end else if (w_inflight0) begin
      r_rsp_valid0 <= 1'b1;
      r_rsp_data0  <= alu_out;
    end else if (r_rsp_valid0 & r0_rsp_ready) begin
      r_rsp_valid0 <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid1 <= 1'b0;
      r_rsp_data1  <= '0;
    end else if (w_inflight1) begin
      r_rsp_valid1 <= 1'b1;
      r_rsp_data1  <= alu_out;
    end else if (r_rsp_valid1 & r1_rsp_ready) begin
      r_rsp_valid1 <= 1'b0;
    end
  end

  assign r0_rsp_valid = r_rsp_valid0;
  assign r0_rsp_data  = r_rsp_data0;
  assign r1_rsp_valid = r_rsp_valid1;
  assign r1_rsp_data  = r_rsp_data1;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural Alu stub
module tb_alu_arbiter;
  localparam int OPW = 5;
  localparam int DW  = 32;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready;
  logic [OPW-1:0] r0_op;
  logic [DW-1:0]  r0_a, r0_b, r0_rsp_data;
  logic           r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready;
  logic [OPW-1:0] r1_op;
  logic [DW-1:0]  r1_a, r1_b, r1_rsp_data;
  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_a, alu_b;
  logic [DW-1:0]  alu_out = '0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [OPW-1:0] ops [4] = '{5'd0, 5'd3, 5'd10, 5'd29};

  always #5 clk = ~clk;

  alu_arbiter #(.OPW(OPW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_rsp_data(r0_rsp_data),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_rsp_data(r1_rsp_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
  );

  function automatic logic [DW-1:0] golden(input logic [OPW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] n;
    logic seen;
    case (op)
      5'd0:  return a + b;
      5'd3:  return a - b;
      5'd10: return {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      5'd29: begin
        n = '0;
        seen = 1'b0;
        for (int k = DW - 1; k >= 0; k--) begin
          if (a[k]) seen = 1'b1;
          if (!seen) n = n + 1;
        end
        return n;
      end
      default: return '0;
    endcase
  endfunction

  // Registered Alu stand-in: unmapped codes hold the output.
  always @(posedge clk) begin
    if (alu_op inside {5'd0, 5'd3, 5'd10, 5'd29}) alu_out <= golden(alu_op, alu_a, alu_b);
  end

  task automatic idle();
    r0_valid = 0; r0_op = '0; r0_a = '0; r0_b = '0; r0_rsp_ready = 1;
    r1_valid = 0; r1_op = '0; r1_a = '0; r1_b = '0; r1_rsp_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    idle();
    rst = 1;
    #2;
    rst = 0;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    @(negedge clk);
    n_tests++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b%0b want 00", r0_ready, r1_ready); end
    n_tests++; if (r0_rsp_valid !== 1'b0 || r1_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %0b%0b want 00", r0_rsp_valid, r1_rsp_valid); end
    n_tests++; if (r0_rsp_data !== '0 || r1_rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp_data: got %h %h want 0", r0_rsp_data, r1_rsp_data); end
    n_tests++; if (alu_op !== 5'd31 || alu_a !== '0 || alu_b !== '0) begin n_fail++; $display("FAIL reset_alu: got op=%0d a=%h b=%h want 31 0 0", alu_op, alu_a, alu_b); end
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_single_op();
    r0_valid = 1; r0_op = 5'd0; r0_a = 5; r0_b = 7;
    @(negedge clk);
    n_tests++; if (r0_ready !== 1'b1) begin n_fail++; $display("FAIL single_accept: r0_ready=%0b want 1", r0_ready); end
    n_tests++; if (alu_op !== 5'd0 || alu_a !== 32'd5 || alu_b !== 32'd7) begin n_fail++; $display("FAIL single_drive: op=%0d a=%0d b=%0d want 0 5 7", alu_op, alu_a, alu_b); end
    tick();
    r0_valid = 0;
    @(negedge clk);
    n_tests++; if (alu_op !== 5'd31) begin n_fail++; $display("FAIL single_idle_op: alu_op=%0d want 31", alu_op); end
    n_tests++; if (r0_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: r0_rsp_valid=%0b want 0", r0_rsp_valid); end
    tick();
    @(negedge clk);
    n_tests++; if (r0_rsp_valid !== 1'b1 || r0_rsp_data !== 32'd12) begin n_fail++; $display("FAIL single_result: valid=%0b data=%0d want 1 12", r0_rsp_valid, r0_rsp_data); end
    tick();
    @(negedge clk);
    n_tests++; if (r0_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: r0_rsp_valid=%0b want 0", r0_rsp_valid); end
    tick();
  endtask

  task automatic test_tie();
    pulse_reset();
    r0_valid = 1; r0_op = 5'd3; r0_a = 10; r0_b = 3;
    r1_valid = 1; r1_op = 5'd10; r1_a = 32'hFFFF_FFFF; r1_b = 1;
    @(negedge clk);
    n_tests++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin n_fail++; $display("FAIL tie_first: ready=%0b%0b want 10", r0_ready, r1_ready); end
    tick();
    r0_valid = 0;
    @(negedge clk);
    n_tests++; if (r1_ready !== 1'b1 || alu_op !== 5'd10) begin n_fail++; $display("FAIL tie_second: r1_ready=%0b op=%0d want 1 10", r1_ready, alu_op); end
    tick();
    r1_valid = 0;
    @(negedge clk);
    n_tests++; if (r0_rsp_valid !== 1'b1 || r0_rsp_data !== 32'd7 || r1_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL tie_r0_result: v0=%0b d0=%0d v1=%0b want 1 7 0", r0_rsp_valid, r0_rsp_data, r1_rsp_valid); end
    tick();
    @(negedge clk);
    n_tests++; if (r1_rsp_valid !== 1'b1 || r1_rsp_data !== 32'd1) begin n_fail++; $display("FAIL tie_r1_result: v1=%0b d1=%0d want 1 1", r1_rsp_valid, r1_rsp_data); end
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    r0_valid = 1; r0_op = 5'd29; r0_a = 32'h0000_FFFF; r0_b = 0; r0_rsp_ready = 0;
    @(negedge clk);
    n_tests++; if (r0_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept: r0_ready=%0b want 1", r0_ready); end
    tick();
    r0_op = 5'd0; r0_a = 2; r0_b = 3;
    @(negedge clk);
    n_tests++; if (r0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_inflight: r0_ready=%0b want 0", r0_ready); end
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++; if (r0_rsp_valid !== 1'b1 || r0_rsp_data !== 32'd16) begin n_fail++; $display("FAIL bp_hold%0d: valid=%0b data=%0d want 1 16", k, r0_rsp_valid, r0_rsp_data); end
      n_tests++; if (r0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_block%0d: r0_ready=%0b want 0", k, r0_ready); end
      tick();
    end
    r0_rsp_ready = 1;
    @(negedge clk);
    n_tests++; if (r0_ready !== 1'b1 || r0_rsp_data !== 32'd16) begin n_fail++; $display("FAIL bp_drain_issue: ready=%0b data=%0d want 1 16", r0_ready, r0_rsp_data); end
    tick();
    r0_valid = 0;
    @(negedge clk);
    n_tests++; if (r0_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: valid=%0b want 0", r0_rsp_valid); end
    tick();
    @(negedge clk);
    n_tests++; if (r0_rsp_valid !== 1'b1 || r0_rsp_data !== 32'd5) begin n_fail++; $display("FAIL bp_next: valid=%0b data=%0d want 1 5", r0_rsp_valid, r0_rsp_data); end
    tick();
    tick();
  endtask

  task automatic test_policy();
    r0_valid = 1; r0_op = 5'd0; r0_a = 1; r0_b = 2;
    @(negedge clk);
    n_tests++; if (r0_ready !== 1'b1) begin n_fail++; $display("FAIL policy_first: r0_ready=%0b want 1", r0_ready); end
    tick();
    tick();
    r1_valid = 1; r1_op = 5'd3; r1_a = 9; r1_b = 4;
    @(negedge clk);
    n_tests++; if (r0_ready !== !RR || r1_ready !== RR) begin n_fail++; $display("FAIL policy_tie: ready=%0b%0b want %0b%0b", r0_ready, r1_ready, !RR, RR); end
    tick();
    idle();
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_op();
    r0_valid = 1; r0_op = 5'd0; r0_a = 9; r0_b = 9; r0_rsp_ready = 0;
    tick();
    r0_valid = 0;
    tick();
    @(negedge clk);
    n_tests++; if (r0_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pending: valid=%0b want 1", r0_rsp_valid); end
    tick();
    rst = 1;
    #1;
    n_tests++; if (r0_rsp_valid !== 1'b0 || r0_rsp_data !== '0) begin n_fail++; $display("FAIL rstmid_async: valid=%0b data=%h want 0 0", r0_rsp_valid, r0_rsp_data); end
    #1;
    rst = 0;
    r0_rsp_ready = 1;
    tick();
    r1_valid = 1; r1_op = 5'd0; r1_a = 1; r1_b = 1;
    @(negedge clk);
    n_tests++; if (r1_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_accept: r1_ready=%0b want 1", r1_ready); end
    tick();
    r1_valid = 0;
    rst = 1;
    #2;
    rst = 0;
    @(negedge clk);
    n_tests++; if (r1_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_t1: r1_rsp_valid=%0b want 0", r1_rsp_valid); end
    tick();
    r1_valid = 1; r1_op = 5'd0; r1_a = 4; r1_b = 4;
    @(negedge clk);
    n_tests++; if (r1_ready !== 1'b1 || r1_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_reissue: ready=%0b rsp_valid=%0b want 1 0", r1_ready, r1_rsp_valid); end
    tick();
    r1_valid = 0;
    @(negedge clk);
    n_tests++; if (r1_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_discard: r1_rsp_valid=%0b want 0", r1_rsp_valid); end
    tick();
    @(negedge clk);
    n_tests++; if (r1_rsp_valid !== 1'b1 || r1_rsp_data !== 32'd8) begin n_fail++; $display("FAIL rstmid_result: valid=%0b data=%0d want 1 8", r1_rsp_valid, r1_rsp_data); end
    tick();
    tick();
  endtask

  // Reference: each requester owns at most one op; its result becomes visible
  // two cycles after acceptance and stays until consumed.
  task automatic test_traffic(input int ncyc, input bit stream);
    logic v [2], rr [2], vis [2], el [2], g [2], gr [2], got_rv [2];
    logic [OPW-1:0] op [2];
    logic [DW-1:0] a [2], b [2], got_rd [2], m_res [2];
    logic m_busy [2];
    int m_acc [2];
    logic m_last;
    logic [OPW-1:0] eop;
    logic [DW-1:0] ea, eb;
    int ndone;
    pulse_reset();
    m_busy = '{1'b0, 1'b0};
    m_acc = '{0, 0};
    m_last = 1'b1;
    ndone = 0;
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < 2; i++) begin
        v[i]  = stream ? 1'b1 : ($urandom_range(0, 3) != 0);
        rr[i] = stream ? 1'b1 : ($urandom_range(0, 2) != 0);
        op[i] = ops[$urandom_range(0, 3)];
        a[i]  = $urandom;
        b[i]  = ($urandom_range(0, 3) == 0) ? a[i] : $urandom;
      end
      r0_valid = v[0]; r0_op = op[0]; r0_a = a[0]; r0_b = b[0]; r0_rsp_ready = rr[0];
      r1_valid = v[1]; r1_op = op[1]; r1_a = a[1]; r1_b = b[1]; r1_rsp_ready = rr[1];
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        vis[i] = m_busy[i] && (c >= m_acc[i] + 2);
        el[i]  = v[i] && (!m_busy[i] || (vis[i] && rr[i]));
      end
      g[0] = el[0] && (!el[1] || !RR || m_last);
      g[1] = el[1] && !g[0];
      eop = g[0] ? op[0] : (g[1] ? op[1] : 5'd31);
      ea  = g[0] ? a[0]  : (g[1] ? a[1]  : '0);
      eb  = g[0] ? b[0]  : (g[1] ? b[1]  : '0);
      gr = '{r0_ready, r1_ready};
      got_rv = '{r0_rsp_valid, r1_rsp_valid};
      got_rd = '{r0_rsp_data, r1_rsp_data};
      for (int i = 0; i < 2; i++) begin
        n_tests++; if (gr[i] !== g[i]) begin n_fail++; $display("FAIL traffic_ready r%0d c%0d: got %0b want %0b", i, c, gr[i], g[i]); end
        n_tests++; if (got_rv[i] !== vis[i]) begin n_fail++; $display("FAIL traffic_rsp_valid r%0d c%0d: got %0b want %0b", i, c, got_rv[i], vis[i]); end
        if (vis[i]) begin
          n_tests++; if (got_rd[i] !== m_res[i]) begin n_fail++; $display("FAIL traffic_rsp_data r%0d c%0d: got %h want %h", i, c, got_rd[i], m_res[i]); end
        end
      end
      n_tests++; if (alu_op !== eop || alu_a !== ea || alu_b !== eb) begin n_fail++; $display("FAIL traffic_alu c%0d: got %0d %h %h want %0d %h %h", c, alu_op, alu_a, alu_b, eop, ea, eb); end
      if (stream) begin
        n_tests++; if (r1_ready !== (c % 2 == 1) || r0_ready !== (c % 2 == 0)) begin n_fail++; $display("FAIL stream_alternate c%0d: ready=%0b%0b want r%0d", c, r0_ready, r1_ready, c % 2); end
      end
      for (int i = 0; i < 2; i++) begin
        if (vis[i] && rr[i]) begin
          m_busy[i] = 1'b0;
          ndone++;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (g[i]) begin
          m_busy[i] = 1'b1;
          m_acc[i]  = c;
          m_res[i]  = golden(op[i], a[i], b[i]);
          m_last    = (i == 1);
        end
      end
      tick();
    end
    if (stream) begin
      n_tests++; if (ndone < ncyc - 2) begin n_fail++; $display("FAIL stream_throughput: got %0d results want >= %0d", ndone, ncyc - 2); end
    end
    idle();
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_tie();
    test_backpressure();
    test_policy();
    test_reset_mid_op();
    test_traffic(40, 1'b1);
    test_traffic(400, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter that shares the single registered `Alu` between the execute stage (requester 0) and the branch/compare unit (requester 1). It accepts operations over valid/ready handshakes and drives `Alu`'s op/a/b inputs. It tracks the one-cycle ALU latency with an in-flight tag and returns each result through a one-entry, per-requester response buffer with its own valid/ready handshake. It sits between the two requesters and the `Alu` instance, and it is the only driver of that instance.

## Interface
- `OPW`, 5, ALU op width (matches `Alu.op`)
- `DW`, 32, operand/result width
- `clk` in 1: sole clock; all state updates on posedge
- `rst` in 1: asynchronous, active-high reset
- `r0_valid` in 1: requester 0 has an operation
- `r0_ready` out 1: requester 0 operation accepted this cycle when `r0_valid & r0_ready`
- `r0_op` in OPW: ALU op code (the `Alu` encoding, e.g. ADD1=0, SUB=3, LT=10, CLZ=29)
- `r0_a`, `r0_b` in DW: operands
- `r0_rsp_valid` out 1: response buffer 0 holds a result
- `r0_rsp_ready` in 1: requester 0 consumes the response
- `r0_rsp_data` out DW: result
- `r1_*`: identical set for requester 1
- `alu_op` out OPW, `alu_a` out DW, `alu_b` out DW: to `Alu.op/a/b`
- `alu_out` in DW: from `Alu.out` (registered inside `Alu`)

## Operation
- Eligibility: `elig_i = r_i_valid & ~inflight_i & (~rsp_valid_i | rsp_ready_i)`. Each requester has at most one operation outstanding.
- Grant: at most one requester per cycle. If only one requester is eligible, it is granted. If both are eligible, the winner is set by the arbitration policy (see Configuration).
- `r_i_ready = grant_i`. It is combinational from eligibility and the pointer and never depends on `r_i_valid` of the other requester beyond arbitration.
- ALU drive: on a grant, `alu_op/a/b` = the granted requester's `op/a/b`, combinationally in the same cycle. With no grant, the block drives `alu_op=5'd31` (unmapped code, so `Alu` holds its output) and `alu_a=alu_b=0`.
- In-flight tag: registers {`tag_valid`, `tag_id`} are set at the end of an accept cycle. `inflight_i = tag_valid & tag_id==i`.
- Capture: in the cycle after an accept, `alu_out` is written into `rsp_data_{tag_id}` and `rsp_valid_{tag_id}` is set. The tag is cleared unless a new accept occurs in the same cycle.
- Response drain: `rsp_valid_i` clears when `rsp_valid_i & rsp_ready_i` and no capture targets i that cycle. Capture and drain of the same buffer in one cycle cannot occur, because eligibility forbids it.
- `rst` clears `tag_valid`, both `rsp_valid`, both `rsp_data` (to 0) and the RR pointer (to prefer r0). Any in-flight result is discarded.

## Timing
- Reset values: `r0_ready`/`r1_ready` follow eligibility and are 0 while no `r_i_valid` is high. `r*_rsp_valid`=0. `r*_rsp_data`=0. `alu_op`=31, `alu_a`=`alu_b`=0.
- Latency: accept in cycle T → `Alu` registers in T → capture at end of T+1 → `r_i_rsp_valid`=1 in T+2.
- Throughput: one ALU issue per cycle in aggregate. Each requester can issue at most once every 2 cycles with a zero-wait consumer.
- Backpressure: while `r_i_rsp_ready`=0, `r_i_rsp_data` is held stable and `r_i_ready`=0.
- Simultaneous events: a buffer drains in T+2 (`rsp_ready`=1) while the same requester issues again in T+2. This is legal and yields back-to-back results every 2 cycles.
- `rst` asserted mid-operation: all outputs go to their reset values asynchronously. The first accept is possible in the first cycle after deassertion.

## Configuration
- `ALU_ARB_ROUND_ROBIN_EN` defined: a 1-bit pointer records the last granted requester. When both requesters are eligible, the one not last granted wins. The pointer updates on every accept.
- Not defined: fixed priority, where r0 always wins a tie. The pointer register is not built.

## Test plan
- Single op: r0 ADD1 a=5 b=7 accepted in T → `r0_rsp_valid`=1 in T+2 with data 12. `alu_op`=31 in T+1.
- Tie after reset: r0 SUB 10,3 and r1 LT 0xFFFFFFFF,1, both valid in T → r0 is granted in T and r1 in T+1. r0 gets 7 in T+2 and r1 gets 1 in T+3.
- Backpressure: r0 CLZ a=0x0000FFFF with `r0_rsp_ready`=0 for 5 cycles → data 16 is held and `r0_ready`=0 throughout. After the drain, a new r0 op is accepted in the same cycle.
- Arbitration policy: r0 is accepted alone in T, then both are eligible in T+2. With `ALU_ARB_ROUND_ROBIN_EN`, r1 is granted. Without it, r0 is granted.
- Reset mid-op: r1 ADD1 1,1 is accepted in T and `rst` pulses in T+1 → `r1_rsp_valid` never rises. After release, an r1 op is accepted on its first valid cycle.
- Streaming: both requesters are continuously valid with `rsp_ready`=1 → grants alternate r0, r1, r0…, the ALU issues every cycle, and every result matches the golden model.
